// File: rtl/fifo_arb_pkg.sv
// Shared sizing helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int N_REQ_DEF      = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_BITS_DEF  = 4;
  localparam int DEPTH          = 2**ADDR_BITS_DEF - 1;
  localparam int GID_W          = clog2(N_REQ_DEF);
  localparam int CRED_W         = ADDR_BITS_DEF;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; req_lock_i exists only with FIFO_ARB_LOCK_EN.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) ();
  localparam int GW = clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]            req_ready_o;
`ifdef FIFO_ARB_LOCK_EN
  logic [N_REQ-1:0]            req_lock_i;
`endif
  logic                        fifo_w_en_o;
  logic [DATA_WIDTH-1:0]       fifo_data_o;
  logic                        fifo_rd_i;
  logic [GW-1:0]               grant_id_o;
  logic [ADDR_BITS-1:0]        level_o;
  logic                        underflow_err_o;

  modport master (
`ifdef FIFO_ARB_LOCK_EN
    output req_lock_i,
`endif
    output req_valid_i, req_data_i, fifo_rd_i,
    input  req_ready_o, fifo_w_en_o, fifo_data_o, grant_id_o, level_o, underflow_err_o
  );

  modport slave (
`ifdef FIFO_ARB_LOCK_EN
    input  req_lock_i,
`endif
    input  req_valid_i, req_data_i, fifo_rd_i,
    output req_ready_o, fifo_w_en_o, fifo_data_o, grant_id_o, level_o, underflow_err_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts just after ptr, first requester wins.
// Zero latency; no state, no backpressure of its own.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int GW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [GW-1:0]    idx,
  output logic             any
);
  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = GW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one fifo_sync write port; credit counter blocks writes to a full FIFO.
// Accept at E -> w_en in E+1, data in E+2. Optional burst lock with FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input logic              clk_i,
  input logic              reset_i,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = clog2(N_REQ);
  localparam logic [ADDR_BITS-1:0] DEPTH_C = {ADDR_BITS{1'b1}};

  logic [ADDR_BITS-1:0]  credits;
  logic [GW-1:0]         rr_ptr;
  logic [N_REQ-1:0]      arb_grant, win_grant;
  logic [GW-1:0]         arb_idx, win_idx;
  logic                  arb_any, win_any;
  logic                  acc, rd_ok;
  logic [DATA_WIDTH-1:0] acc_word, s1_dat, data_q;
  logic                  w_en, err_q;
  logic [GW-1:0]         gid_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_valid_i),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef FIFO_ARB_LOCK_EN
  logic lock_live, hold;

  // rr_ptr doubles as the lock owner: it is always the last accepted requester.
  assign hold = lock_live & bus.req_lock_i[rr_ptr] & bus.req_valid_i[rr_ptr];

  always_comb begin
    win_grant = arb_grant;
    win_idx   = arb_idx;
    win_any   = arb_any;
    if (hold) begin
      win_grant = N_REQ'(1) << rr_ptr;
      win_idx   = rr_ptr;
      win_any   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)  lock_live <= 1'b0;
    else if (acc) lock_live <= 1'b1;
    else          lock_live <= hold;
  end
`else
  assign win_grant = arb_grant;
  assign win_idx   = arb_idx;
  assign win_any   = arb_any;
`endif

  assign bus.req_ready_o = (credits != '0) ? win_grant : '0;
  assign acc      = win_any && (credits != '0);
  assign acc_word = bus.req_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign rd_ok    = bus.fifo_rd_i && (credits != DEPTH_C);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits <= DEPTH_C;
      rr_ptr  <= GW'(N_REQ - 1);
      gid_q   <= '0;
      s1_dat  <= '0;
      w_en    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case ({acc, rd_ok})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      if (acc) begin
        rr_ptr <= win_idx;
        gid_q  <= win_idx;
        s1_dat <= acc_word;
      end
      // Data trails w_en by a cycle to line up with fifo_sync's registered w_en.
      w_en <= acc;
      if (w_en) data_q <= s1_dat;
      if (bus.fifo_rd_i && (credits == DEPTH_C)) err_q <= 1'b1;
    end
  end

  assign bus.fifo_w_en_o     = w_en;
  assign bus.fifo_data_o     = data_q;
  assign bus.grant_id_o      = gid_q;
  assign bus.level_o         = DEPTH_C - credits;
  assign bus.underflow_err_o = err_q;

endmodule
